// File: rtl/cpu_loader.sv
// cpu_loader: stream-driven boot loader for the pipelined RISC-V CPU.
//
// Consumes a 32-bit command/data stream over a valid/ready handshake and turns
// it into writes on the CPU's instruction-memory (32-bit) and data-memory
// (64-bit) load ports. It also owns the CPU enable, which is raised only by an
// explicit START command.
//
// Ports:
//   clk, arst                 clock, asynchronous active-high reset
//   s_valid, s_data, s_ready  command/data word stream (never back-pressured)
//   imem_addr/wen/wdata       instruction-memory load port, one strobe per word
//   dmem_addr/wen/wdata       data-memory load port, one strobe per doubleword
//   cpu_enable                CPU run enable
//   busy                      high while a load burst is in progress
//   error                     sticky error (illegal command or bad range)
module cpu_loader #(
  parameter int unsigned IMEM_LIMIT = 512,
  parameter int unsigned DMEM_LIMIT = 8192
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic [63:0] imem_addr,
  output logic        imem_wen,
  output logic [31:0] imem_wdata,
  output logic [63:0] dmem_addr,
  output logic        dmem_wen,
  output logic [63:0] dmem_wdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error
);

  localparam logic [3:0] CMD_NOP     = 4'h0;
  localparam logic [3:0] CMD_LOAD_I  = 4'h1;
  localparam logic [3:0] CMD_LOAD_D  = 4'h2;
  localparam logic [3:0] CMD_START   = 4'h3;
  localparam logic [3:0] CMD_HALT    = 4'h4;
  localparam logic [3:0] CMD_CLR_ERR = 4'h5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA_I,
    DATA_LO,
    DATA_HI
  } state_t;

  state_t      state;
  logic        load_d;     // current burst targets data memory
  logic [15:0] count;      // burst length latched from the header
  logic [15:0] remaining;  // writes still to perform in this burst
  logic [63:0] cur_addr;   // address of the next write
  logic [31:0] lo_word;    // low half of the doubleword being assembled
  logic        burst_ok;   // range check passed; strobes allowed
  logic        accept;

  // 34-bit end-of-burst address: a 32-bit base plus up to 8*65535 cannot wrap.
  logic [33:0] end_i;
  logic [33:0] end_d;
  logic        range_bad;

  // The loader never back-pressures; it only refuses words while in reset.
  assign s_ready = ~arst;
  assign accept  = s_valid & s_ready;
  assign busy    = (state != IDLE);

  always_comb begin
    end_i     = {2'b00, s_data} + {16'b0, count, 2'b00};
    end_d     = {2'b00, s_data} + {15'b0, count, 3'b000};
    range_bad = 1'b0;
    if (load_d)
      range_bad = (s_data[2:0] != 3'b000) || (end_d > 34'(DMEM_LIMIT));
    else
      range_bad = (s_data[1:0] != 2'b00) || (end_i > 34'(IMEM_LIMIT));
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      load_d     <= 1'b0;
      count      <= '0;
      remaining  <= '0;
      cur_addr   <= '0;
      lo_word    <= '0;
      burst_ok   <= 1'b0;
      imem_addr  <= '0;
      imem_wen   <= 1'b0;
      imem_wdata <= '0;
      dmem_addr  <= '0;
      dmem_wen   <= 1'b0;
      dmem_wdata <= '0;
      cpu_enable <= 1'b0;
      error      <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses.
      imem_wen <= 1'b0;
      dmem_wen <= 1'b0;
      if (accept) begin
        unique case (state)
          IDLE: begin
            unique case (s_data[31:28])
              CMD_NOP: ;
              CMD_LOAD_I, CMD_LOAD_D: begin
                load_d     <= (s_data[31:28] == CMD_LOAD_D);
                count      <= s_data[15:0];
                // Stop the CPU before any of the new image reaches memory.
                cpu_enable <= 1'b0;
                state      <= ADDR;
              end
              CMD_START:   cpu_enable <= 1'b1;
              CMD_HALT:    cpu_enable <= 1'b0;
              CMD_CLR_ERR: error      <= 1'b0;
              default:     error      <= 1'b1;
            endcase
          end
          ADDR: begin
            cur_addr  <= {32'b0, s_data};
            remaining <= count;
            // A bad range still consumes the payload so the stream stays in
            // step, but no strobes are issued for this burst.
            burst_ok  <= ~range_bad;
            if (range_bad)
              error <= 1'b1;
            if (count == 16'd0)
              state <= IDLE;
            else if (load_d)
              state <= DATA_LO;
            else
              state <= DATA_I;
          end
          DATA_I: begin
            if (burst_ok) begin
              imem_wen   <= 1'b1;
              imem_addr  <= cur_addr;
              imem_wdata <= s_data;
            end
            cur_addr  <= cur_addr + 64'd4;
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1)
              state <= IDLE;
          end
          DATA_LO: begin
            lo_word <= s_data;
            state   <= DATA_HI;
          end
          DATA_HI: begin
            if (burst_ok) begin
              dmem_wen   <= 1'b1;
              dmem_addr  <= cur_addr;
              dmem_wdata <= {s_data, lo_word};
            end
            cur_addr  <= cur_addr + 64'd8;
            remaining <= remaining - 16'd1;
            state     <= (remaining == 16'd1) ? IDLE : DATA_LO;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_loader.sv
// Testbench for cpu_loader: directed scenarios followed by a randomized command
// stream, each cycle compared against a stream-interpreter reference model.
module tb_cpu_loader;

  localparam int unsigned IMEM_LIMIT = 512;
  localparam int unsigned DMEM_LIMIT = 8192;

  logic        clk = 1'b0;
  logic        arst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [63:0] imem_addr;
  logic        imem_wen;
  logic [31:0] imem_wdata;
  logic [63:0] dmem_addr;
  logic        dmem_wen;
  logic [63:0] dmem_wdata;
  logic        cpu_enable;
  logic        busy;
  logic        error;

  cpu_loader #(.IMEM_LIMIT(IMEM_LIMIT), .DMEM_LIMIT(DMEM_LIMIT)) dut (
    .clk       (clk),
    .arst      (arst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .imem_addr (imem_addr),
    .imem_wen  (imem_wen),
    .imem_wdata(imem_wdata),
    .dmem_addr (dmem_addr),
    .dmem_wen  (dmem_wen),
    .dmem_wdata(dmem_wdata),
    .cpu_enable(cpu_enable),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_iw  = 0;
  int n_dw  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: interprets the stream word by word.
  // m_phase 0 = expecting a header, 1 = expecting a base address,
  // 2 = consuming payload words.
  int              m_phase;
  bit              m_en, m_err, m_is_d, m_ok;
  int              m_count, m_left;
  longint unsigned m_addr;
  logic [31:0]     m_lo;
  bit              e_iwen, e_dwen;
  logic [63:0]     e_iaddr, e_daddr, e_ddata;
  logic [31:0]     e_idata;

  task automatic model_reset();
    m_phase = 0; m_en = 0; m_err = 0; m_is_d = 0; m_ok = 0;
    m_count = 0; m_left = 0; m_addr = 0; m_lo = '0;
  endtask

  task automatic model_word(input logic [31:0] d);
    longint unsigned base, unit, lim;
    bit bad;
    case (m_phase)
      0: begin
        case (d[31:28])
          4'h0: ;
          4'h1, 4'h2: begin
            m_is_d = (d[31:28] == 4'h2); m_count = int'(d[15:0]);
            m_en = 0; m_phase = 1;
          end
          4'h3: m_en = 1;
          4'h4: m_en = 0;
          4'h5: m_err = 0;
          default: m_err = 1;
        endcase
      end
      1: begin
        base = longint'(d);
        unit = m_is_d ? 8 : 4;
        lim  = m_is_d ? DMEM_LIMIT : IMEM_LIMIT;
        bad  = (base % unit != 0) || (base + unit * longint'(m_count) > lim);
        if (bad) m_err = 1;
        m_ok   = !bad;
        m_addr = base;
        m_left = m_is_d ? 2 * m_count : m_count;
        m_phase = (m_left == 0) ? 0 : 2;
      end
      default: begin
        if (!m_is_d) begin
          if (m_ok) begin e_iwen = 1; e_iaddr = m_addr; e_idata = d; end
          m_addr += 4;
        end else if (m_left % 2 == 0) begin
          m_lo = d;
        end else begin
          if (m_ok) begin e_dwen = 1; e_daddr = m_addr; e_ddata = {d, m_lo}; end
          m_addr += 8;
        end
        m_left--;
        if (m_left == 0) m_phase = 0;
      end
    endcase
  endtask

  // Present one word (or a gap), clock it, then compare every output.
  task automatic step(input bit v, input logic [31:0] d);
    s_valid = v;
    s_data  = d;
    @(posedge clk);
    #1;
    e_iwen = 0; e_dwen = 0;
    if (v) model_word(d);
    if (imem_wen) n_iw++;
    if (dmem_wen) n_dw++;
    check_eq("s_ready", 64'(s_ready), 64'd1);
    check_eq("imem_wen", 64'(imem_wen), 64'(e_iwen));
    check_eq("dmem_wen", 64'(dmem_wen), 64'(e_dwen));
    if (e_iwen) begin
      check_eq("imem_addr", imem_addr, e_iaddr);
      check_eq("imem_wdata", 64'(imem_wdata), 64'(e_idata));
    end
    if (e_dwen) begin
      check_eq("dmem_addr", dmem_addr, e_daddr);
      check_eq("dmem_wdata", dmem_wdata, e_ddata);
    end
    check_eq("cpu_enable", 64'(cpu_enable), 64'(m_en));
    check_eq("error", 64'(error), 64'(m_err));
    check_eq("busy", 64'(busy), 64'(m_phase != 0));
  endtask

  task automatic send(input logic [31:0] d);
    if ($urandom_range(0, 3) == 0) step(1'b0, $urandom);
    step(1'b1, d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check_eq({tag, "_wen"}, {62'b0, imem_wen, dmem_wen}, 64'd0);
    check_eq({tag, "_cpu_enable"}, 64'(cpu_enable), 64'd0);
    check_eq({tag, "_error"}, 64'(error), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_imem_addr"}, imem_addr, 64'd0);
    check_eq({tag, "_dmem_addr"}, dmem_addr, 64'd0);
    check_eq({tag, "_dmem_wdata"}, dmem_wdata, 64'd0);
  endtask

  // Hold reset for n edges with s_valid high, then release after an edge.
  task automatic hold_reset(input int n, input string tag);
    arst = 1'b1;
    s_valid = 1'b1;
    s_data = 32'h1000_0004;
    #1;
    check_reset_outputs(tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_reset_outputs(tag);
    end
    arst = 1'b0;
    s_valid = 1'b0;
    model_reset();
    #1;
    check_eq({tag, "_release_ready"}, 64'(s_ready), 64'd1);
  endtask

  initial begin
    int iw0;
    logic [31:0] hdr, base, w;
    int cnt, words, r;
    bit is_d;

    arst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    model_reset();

    hold_reset(3, "rst");

    // LOAD_I three words at 0
    step(1, 32'h1000_0003);
    step(1, 32'h0000_0000);
    step(1, 32'h0050_0093);
    step(1, 32'h0010_0113);
    step(1, 32'h0020_81B3);
    check_eq("loadi_last_data", 64'(imem_wdata), 64'h0020_81B3);
    check_eq("loadi_last_addr", imem_addr, 64'h8);

    // LOAD_D two doublewords at 0x10
    step(1, 32'h2000_0002);
    step(1, 32'h0000_0010);
    step(1, 32'd1);
    step(1, 32'd2);
    check_eq("loadd_first_data", dmem_wdata, 64'h0000_0002_0000_0001);
    step(1, 32'd3);
    step(1, 32'd4);
    check_eq("loadd_second_addr", dmem_addr, 64'h18);

    // Out of range: 0x1FC + 8 > 512
    iw0 = n_iw;
    step(1, 32'h1000_0002);
    step(1, 32'h0000_01FC);
    step(1, 32'hDEAD_BEEF);
    step(1, 32'hCAFE_F00D);
    step(1, 32'h0000_0000);
    check_eq("oor_no_writes", 64'(n_iw - iw0), 64'd0);
    check_eq("oor_error", 64'(error), 64'd1);
    step(1, 32'h5000_0000);

    // Exactly-at-limit bursts are legal
    step(1, 32'h1000_0001); step(1, 32'h0000_01FC); step(1, 32'h1234_5678);
    step(1, 32'h2000_0001); step(1, 32'd8184); step(1, 32'hAAAA_5555); step(1, 32'h5555_AAAA);
    step(1, 32'h2000_0001); step(1, 32'd8188); step(1, 32'd7); step(1, 32'd8); // misaligned
    step(1, 32'h5000_0000);

    // Control commands
    step(1, 32'h3000_0000);
    step(1, 32'h2000_0000);
    step(1, 32'h0000_0000);
    step(1, 32'hF000_0000);
    step(1, 32'h5000_0000);
    step(1, 32'h3000_0000);
    step(1, 32'h4000_0000);

    // Mid-burst reset after two payload words
    iw0 = n_iw;
    step(1, 32'h1000_0004);
    step(1, 32'h0000_0040);
    step(1, 32'h1111_1111);
    step(1, 32'h2222_2222);
    check_eq("midrst_writes", 64'(n_iw - iw0), 64'd2);
    hold_reset(2, "midrst");
    step(1, 32'h3000_0000);
    check_eq("midrst_next_is_cmd", 64'(cpu_enable), 64'd1);
    step(1, 32'h1000_0000);
    step(1, 32'h0000_0000);

    // Randomized command stream
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 6) begin
        is_d  = (r >= 4);
        cnt   = $urandom_range(0, 6);
        hdr   = {is_d ? 4'h2 : 4'h1, 12'($urandom), 16'(cnt)};
        if ($urandom_range(0, 3) != 0)
          base = is_d ? 32'(8 * $urandom_range(0, 1024 - cnt))
                      : 32'(4 * $urandom_range(0, 128 - cnt));
        else
          base = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 9000));
        words = is_d ? 2 * cnt : cnt;
        send(hdr);
        send(base);
        for (int j = 0; j < words; j++) begin
          w = $urandom;
          send(w);
        end
      end else if (r == 7) begin
        send({4'h3, 28'($urandom)});
      end else if (r == 8) begin
        send({($urandom_range(0, 1) == 1) ? 4'h4 : 4'h5, 28'($urandom)});
      end else begin
        send({4'($urandom_range(0, 15)), 28'($urandom)});
        send(32'h5000_0000);
      end
    end
    step(1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
